signed_sat_alu_pipe: RTL and testbench
======================================

# signed_sat_alu_pipe

Parametrised, two-stage pipelined signed arithmetic unit with saturation, the successor to the combinational 4-bit saturating adder. It supports add, subtract, accumulate and accumulator load, and flags every clipped result. It counts clip events in a saturating counter. Valid/ready handshakes on both sides let it sit in a streaming datapath between a source and a sink that may stall.

## Interface
- WIDTH, 8: data width in bits, two's complement, WIDTH >= 2.
- CNT_W, 8: width of the saturation event counter, CNT_W >= 1.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept an operation this cycle.
- op  in  2  operation code: 0 ADD, 1 SUB, 2 ACC, 3 LOAD.
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B; ignored for ACC and LOAD.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts the result this cycle.
- out_sum  out  WIDTH  signed, saturated result.
- out_sat  out  1  result was clipped (high together with out_valid).
- sat_count  out  CNT_W  number of clipped results accepted into stage 1, saturating at 2^CNT_W-1.

## Operation
- MAX = 2^(WIDTH-1)-1 and MIN = -2^(WIDTH-1).
- Exact results are computed at WIDTH+1 bits, sign-extended, so there is no wrap.
- Operations, where acc is the internal WIDTH-bit signed accumulator:
  - ADD: r = a + b.
  - SUB: r = a - b. b = MIN is legal and gives a - MIN exactly.
  - ACC: r = acc + a; acc <= sat(r).
  - LOAD: r = a; acc <= a. Never saturates.
- sat(r) = MAX if r > MAX, MIN if r < MIN, else r. The sat flag is 1 exactly when r falls outside [MIN, MAX].
- Stage 1 (accept):
  - On in_valid && in_ready, register the exact WIDTH+1-bit r and op.
  - The acc update for ACC and LOAD happens on this same edge.
  - Back-to-back ACC operations therefore chain with no hazard or bubble.
- Stage 2 (output): on advance, register sat(r) into out_sum and the sat flag into out_sat, and set out_valid.
- sat_count increments on the stage-1 accept edge when the accepted operation will clip. It holds at 2^CNT_W-1.
- Flow control:
  - stage2 moves when !out_valid || out_ready.
  - stage1 moves when !s1_valid || stage2 moves.
  - in_ready = stage1 moves, which is combinational from out_ready and the two stage valid bits.
- Holding under stall: with out_valid && !out_ready, out_sum, out_sat and out_valid hold stable. Stage 1 also holds if it is full.
- Input side is valid/ready: in_valid may assert without waiting for in_ready. The unit never drops or duplicates an operation.

## Timing
- Reset (async assert, sync release): out_valid=0, out_sum=0, out_sat=0, sat_count=0, acc=0, stage-1 valid=0. in_ready is 1 from the first cycle after reset.
- Latency: an operation accepted at edge N is presented with out_valid=1 after edge N+1, i.e. 2 cycles from the input handshake to result visibility.
- Throughput: one operation per cycle while out_ready=1.
- Capacity: 2 operations in flight. After 2 accepts with out_ready=0, in_ready=0.
- Simultaneous events:
  - Output consumed and new input accepted on the same edge: both take effect, with no bubble.
  - ACC accepted while a previous ACC is still in stage 2: it uses the already-updated acc.
- Reset mid-operation: in-flight results are discarded and acc is cleared. No out_valid pulse for a discarded operation.
- out_sum and out_sat are registered outputs. They carry no combinational path from a, b or op.

## Test plan
- WIDTH=4, out_ready=1:
  - ADD 1+2 -> 3, sat=0.
  - ADD 4+7 -> 7, sat=1.
  - ADD -4+-7 -> -8, sat=1.
  - ADD -3+6 -> 3, sat=0.
  - Each result has out_valid exactly 2 cycles after its accept.
- WIDTH=4 SUB:
  - 3-(-8) -> 7, sat=1.
  - -8-1 -> -8, sat=1.
  - -8-(-8) -> 0, sat=0.
  - 5-3 -> 2, sat=0.
- WIDTH=4, back-to-back accumulator sequence LOAD 5, ACC 1, ACC 3, ACC -8, ACC -8, ACC -8 -> outputs 5, 6, 7(sat), -1, -8(sat=0, exact -9? no: -1-8=-9 -> -8 sat=1), -8(sat=1). Expected sat_count=3.
- Backpressure:
  - Hold out_ready=0 and offer 4 operations: exactly 2 are accepted, in_ready=0, and out_sum is stable.
  - Release out_ready: all 4 results appear in order with no loss or duplication.
- CNT_W=2: drive 5 clipping ADDs -> sat_count reads 1, 2, 3, 3, 3.
- Reset mid-stream:
  - Assert rst with 2 operations in flight and acc=6.
  - out_valid drops immediately, with no stale output after release.
  - A following ACC 1 yields 1, showing acc was cleared.

Source files
------------

// File: rtl/signed_sat_alu_pipe_if.sv
// Stream bundle for the saturating ALU pipe: operation input side and result output side.
// The unit takes the slave modport; the source/sink environment takes master.
interface signed_sat_alu_pipe_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
);
   logic                    in_valid;
   logic                    in_ready;
   logic [1:0]              op;
   logic signed [WIDTH-1:0] a;
   logic signed [WIDTH-1:0] b;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] out_sum;
   logic                    out_sat;
   logic [CNT_W-1:0]        sat_count;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, out_sum, out_sat, sat_count
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, out_sum, out_sat, sat_count
   );
endinterface

// File: rtl/signed_sat_alu_pipe.sv
// Two-stage signed saturating ALU (ADD/SUB/ACC/LOAD) with valid/ready on both sides.
// Stage 1 holds the exact WIDTH+1-bit result; stage 2 holds the clipped result and flag.
module signed_sat_alu_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input logic                  clk,
   input logic                  rst,
   signed_sat_alu_pipe_if.slave bus
);

   typedef enum logic [1:0] {
      OpAdd  = 2'd0,
      OpSub  = 2'd1,
      OpAcc  = 2'd2,
      OpLoad = 2'd3
   } op_e;

   // Clipped exactly when the two top bits of the exact result disagree.
   function automatic logic clips(input logic signed [WIDTH:0] v);
      return v[WIDTH] ^ v[WIDTH-1];
   endfunction

   function automatic logic signed [WIDTH-1:0] sat_val(input logic signed [WIDTH:0] v);
      if (!clips(v)) begin
         return v[WIDTH-1:0];
      end else if (v[WIDTH]) begin
         return {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         return {1'b0, {(WIDTH-1){1'b1}}};
      end
   endfunction

   logic                    s1_valid_q;
   logic signed [WIDTH:0]   s1_r_q;
   logic signed [WIDTH-1:0] acc_q;
   logic                    out_valid_q;
   logic signed [WIDTH-1:0] out_sum_q;
   logic                    out_sat_q;
   logic [CNT_W-1:0]        sat_cnt_q;

   logic                    s2_move;
   logic                    s1_move;
   logic                    accept;
   logic signed [WIDTH:0]   a_x;
   logic signed [WIDTH:0]   b_x;
   logic signed [WIDTH:0]   acc_x;
   logic signed [WIDTH:0]   r_next;

   assign s2_move = !out_valid_q || bus.out_ready;
   assign s1_move = !s1_valid_q || s2_move;
   assign accept  = bus.in_valid && s1_move;

   always_comb begin
      a_x    = {bus.a[WIDTH-1], bus.a};
      b_x    = {bus.b[WIDTH-1], bus.b};
      acc_x  = {acc_q[WIDTH-1], acc_q};
      r_next = a_x;
      unique case (op_e'(bus.op))
         OpAdd:   r_next = a_x + b_x;
         OpSub:   r_next = a_x - b_x;
         OpAcc:   r_next = acc_x + a_x;
         OpLoad:  r_next = a_x;
         default: r_next = a_x;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_r_q      <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_sat_q   <= 1'b0;
         sat_cnt_q   <= '0;
      end else begin
         if (s1_move) begin
            s1_valid_q <= accept;
         end
         if (accept) begin
            s1_r_q <= r_next;
            // LOAD's exact result is a itself, so sat_val leaves it untouched.
            if (bus.op == OpAcc || bus.op == OpLoad) begin
               acc_q <= sat_val(r_next);
            end
            if (clips(r_next) && !(&sat_cnt_q)) begin
               sat_cnt_q <= sat_cnt_q + CNT_W'(1);
            end
         end
         if (s2_move) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_sum_q <= sat_val(s1_r_q);
               out_sat_q <= clips(s1_r_q);
            end
         end
      end
   end

   assign bus.in_ready  = s1_move;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_sat   = out_sat_q;
   assign bus.sat_count = sat_cnt_q;

endmodule

// File: tb/tb_signed_sat_alu_pipe.sv
// Bench for signed_sat_alu_pipe at WIDTH=4: directed plan steps, then random traffic
// checked against an integer reference model and scoreboard.
module tb_signed_sat_alu_pipe;

   localparam int MAXV = 7;
   localparam int MINV = -8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   signed_sat_alu_pipe_if #(.WIDTH(4), .CNT_W(8)) ifm ();
   signed_sat_alu_pipe_if #(.WIDTH(4), .CNT_W(2)) ifc ();

   // The narrow-counter copy sees exactly the same stream as the main unit.
   assign ifc.in_valid  = ifm.in_valid;
   assign ifc.op        = ifm.op;
   assign ifc.a         = ifm.a;
   assign ifc.b         = ifm.b;
   assign ifc.out_ready = ifm.out_ready;

   signed_sat_alu_pipe #(.WIDTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(ifm));
   signed_sat_alu_pipe #(.WIDTH(4), .CNT_W(2)) dut_c2 (.clk(clk), .rst(rst), .bus(ifc));

   int n_chk = 0;
   int n_err = 0;
   int exp_sum_q[$];
   bit exp_sat_q[$];
   int obs_q[$];
   bit obs_sat_q[$];
   int m_acc = 0;
   int m_cnt8 = 0;
   int m_cnt2 = 0;
   int n_acc = 0;
   bit took = 1'b0;
   bit stall_p = 1'b0;
   int hold_sum;
   int hold_sat;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_accept(input int op, input int av, input int bv);
      int r;
      int s;
      bit sat;
      case (op)
         0:       r = av + bv;
         1:       r = av - bv;
         2:       r = m_acc + av;
         default: r = av;
      endcase
      sat = (r > MAXV) || (r < MINV);
      s   = (r > MAXV) ? MAXV : ((r < MINV) ? MINV : r);
      if (op == 2) m_acc = s;
      if (op == 3) m_acc = av;
      if (sat) begin
         if (m_cnt8 < 255) m_cnt8++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      exp_sum_q.push_back(s);
      exp_sat_q.push_back(sat);
      n_acc++;
   endtask

   // Scoreboard and model, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         took    = 1'b0;
         stall_p = 1'b0;
      end else begin
         check("sat_count_w8", int'(ifm.sat_count), m_cnt8);
         check("sat_count_w2", int'(ifc.sat_count), m_cnt2);
         if (stall_p) begin
            check("hold_valid", int'(ifm.out_valid), 1);
            check("hold_sum", int'(ifm.out_sum), hold_sum);
            check("hold_sat", int'(ifm.out_sat), hold_sat);
         end
         if (ifm.out_valid && ifm.out_ready) begin
            check("out_pending", (exp_sum_q.size() > 0) ? 1 : 0, 1);
            if (exp_sum_q.size() > 0) begin
               check("sb_sum", int'(ifm.out_sum), exp_sum_q.pop_front());
               check("sb_sat", int'(ifm.out_sat), int'(exp_sat_q.pop_front()));
            end
            obs_q.push_back(int'(ifm.out_sum));
            obs_sat_q.push_back(ifm.out_sat);
         end
         stall_p  = ifm.out_valid && !ifm.out_ready;
         hold_sum = int'(ifm.out_sum);
         hold_sat = int'(ifm.out_sat);
         took     = ifm.in_valid && ifm.in_ready;
         if (took) model_accept(int'(ifm.op), int'(ifm.a), int'(ifm.b));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one operation and returns 1 ns after the edge that accepts it.
   task automatic offer(input logic [1:0] o, input int av, input int bv);
      bit done;
      done = 1'b0;
      ifm.op       = o;
      ifm.a        = av[3:0];
      ifm.b        = bv[3:0];
      ifm.in_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (ifm.in_ready) begin
            tick();
            done = 1'b1;
         end
      end
      ifm.in_valid = 1'b0;
      if (!done) begin
         n_chk++;
         n_err++;
         $error("FAIL offer_timeout: got no in_ready expected accept within 50 cycles");
      end
   endtask

   // Single op into an empty pipe with out_ready=1: result visible after accept edge + 1.
   task automatic single(input logic [1:0] o, input int av, input int bv,
                         input int es, input int esat);
      offer(o, av, bv);
      @(negedge clk);
      check("lat_early_valid", int'(ifm.out_valid), 0);
      @(negedge clk);
      check("lat_valid", int'(ifm.out_valid), 1);
      check("single_sum", int'(ifm.out_sum), es);
      check("single_sat", int'(ifm.out_sat), esat);
      tick();
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      ifm.out_ready = 1'b1;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         if (exp_sum_q.size() == 0) done = 1'b1;
      end
      if (!done) begin
         n_chk++;
         n_err++;
         $error("FAIL drain_timeout: got %0d pending expected 0", exp_sum_q.size());
      end
      tick();
   endtask

   task automatic clear_model();
      exp_sum_q.delete();
      exp_sat_q.delete();
      m_acc  = 0;
      m_cnt8 = 0;
      m_cnt2 = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_model();
      #1;
      check("rst_out_valid", int'(ifm.out_valid), 0);
      tick();
      rst = 1'b0;
   endtask

   task automatic cmp_obs(input string tag, input int base, input int exp_s[6],
                          input bit exp_f[6], input int n);
      check({tag, "_count"}, obs_q.size() - base, n);
      for (int i = 0; i < n; i++) begin
         check({tag, "_sum"}, (base + i < obs_q.size()) ? obs_q[base+i] : 99, exp_s[i]);
         check({tag, "_sat"}, (base + i < obs_q.size()) ? int'(obs_sat_q[base+i]) : 99,
               int'(exp_f[i]));
      end
   endtask

   initial begin
      int base;
      int acc0;
      int c2_exp[5];
      int chain_s[6];
      bit chain_f[6];
      int bp_s[6];
      bit bp_f[6];
      logic [31:0] rv;

      rst           = 1'b1;
      ifm.in_valid  = 1'b0;
      ifm.op        = 2'd0;
      ifm.a         = '0;
      ifm.b         = '0;
      ifm.out_ready = 1'b1;

      @(negedge clk);
      check("reset_out_valid", int'(ifm.out_valid), 0);
      check("reset_out_sum", int'(ifm.out_sum), 0);
      check("reset_out_sat", int'(ifm.out_sat), 0);
      check("reset_sat_count", int'(ifm.sat_count), 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_in_ready", int'(ifm.in_ready), 1);
      tick();

      // ADD and SUB with out_ready held high.
      single(2'd0, 1, 2, 3, 0);
      single(2'd0, 4, 7, 7, 1);
      single(2'd0, -4, -7, -8, 1);
      single(2'd0, -3, 6, 3, 0);
      single(2'd1, 3, -8, 7, 1);
      single(2'd1, -8, 1, -8, 1);
      single(2'd1, -8, -8, 0, 0);
      single(2'd1, 5, 3, 2, 0);
      check("cnt_after_add_sub", int'(ifm.sat_count), 4);

      // Back-to-back accumulator chain.
      base = obs_q.size();
      chain_s = '{5, 6, 7, -1, -8, -8};
      chain_f = '{0, 0, 1, 0, 1, 1};
      offer(2'd3, 5, 0);
      offer(2'd2, 1, 0);
      offer(2'd2, 3, 0);
      offer(2'd2, -8, 0);
      offer(2'd2, -8, 0);
      offer(2'd2, -8, 0);
      drain();
      cmp_obs("acc_chain", base, chain_s, chain_f, 6);
      check("acc_chain_cnt", int'(ifm.sat_count), 7);

      // Backpressure: two accepted, then stalled with stable output.
      base = obs_q.size();
      acc0 = n_acc;
      ifm.out_ready = 1'b0;
      offer(2'd0, 1, 1);
      offer(2'd0, 2, 2);
      ifm.op       = 2'd0;
      ifm.a        = 4'sd3;
      ifm.b        = 4'sd3;
      ifm.in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("bp_in_ready", int'(ifm.in_ready), 0);
         check("bp_out_valid", int'(ifm.out_valid), 1);
         check("bp_out_sum", int'(ifm.out_sum), 2);
      end
      check("bp_accepted", n_acc - acc0, 2);
      tick();
      ifm.out_ready = 1'b1;
      offer(2'd0, 3, 3);
      offer(2'd0, 3, 4);
      drain();
      bp_s = '{2, 4, 6, 7, 0, 0};
      bp_f = '{0, 0, 0, 0, 0, 0};
      cmp_obs("bp", base, bp_s, bp_f, 4);

      // Narrow counter saturates at 3.
      do_reset();
      c2_exp = '{1, 2, 3, 3, 3};
      for (int i = 0; i < 5; i++) begin
         offer(2'd0, 7, 7);
         @(negedge clk);
         check("c2_count", int'(ifc.sat_count), c2_exp[i]);
         tick();
      end
      drain();
      check("c8_after_five", int'(ifm.sat_count), 5);

      // Reset with two operations in flight and acc=6.
      ifm.out_ready = 1'b0;
      offer(2'd3, 6, 0);
      offer(2'd0, 1, 1);
      do_reset();
      base = obs_q.size();
      ifm.out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_valid", int'(ifm.out_valid), 0);
      end
      check("post_rst_no_output", obs_q.size() - base, 0);
      tick();
      single(2'd2, 1, 0, 1, 0);

      // Random traffic with random sink stalls.
      for (int i = 0; i < 400; i++) begin
         if (!ifm.in_valid || took) begin
            rv           = $urandom;
            ifm.in_valid = (rv[9:8] != 2'd0);
            ifm.op       = rv[5:4];
            ifm.a        = rv[3:0];
            ifm.b        = rv[13:10];
         end
         rv            = $urandom;
         ifm.out_ready = (rv[1:0] != 2'd0);
         tick();
      end
      ifm.in_valid = 1'b0;
      drain();
      check("final_empty", exp_sum_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
